// File: rtl/sigmoid_req_scheduler.sv
// sigmoid_req_scheduler: round-robin front end that time-shares one sigmoid core
// between NREQ requesters, one operation in flight, result returned with its owner id.
module sigmoid_req_scheduler #(
  parameter int NREQ     = 4,
  parameter int IDW      = 2,
  parameter int CORE_LAT = 0
)(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [16*NREQ-1:0]   req_x,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [15:0]          rsp_y,
  output logic [15:0]          core_x,
  input  logic [15:0]          core_y,
  output logic                 busy,
  output logic [15:0]          done_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t         r_state, w_state_nxt;
  logic [IDW-1:0] r_rr_ptr, r_id;
  logic [15:0]    r_x, r_y, r_done_cnt;
  logic [3:0]     r_cnt;

  logic           w_any, w_accept, w_rsp_hs;
  logic [IDW-1:0] w_gnt, w_ptr_nxt;
  logic [15:0]    w_gnt_x;
  int             w_best, w_dist;

  // Pick the valid requester closest to rr_ptr going upward with wrap.
  always_comb begin
    w_any  = 1'b0;
    w_gnt  = '0;
    w_best = NREQ;
    w_dist = 0;
    for (int i = 0; i < NREQ; i++) begin
      w_dist = (i >= int'(r_rr_ptr)) ? i - int'(r_rr_ptr) : i + NREQ - int'(r_rr_ptr);
      if (req_valid[i] && w_dist < w_best) begin
        w_best = w_dist;
        w_any  = 1'b1;
        w_gnt  = IDW'(i);
      end
    end
  end

  // Grants are only offered in IDLE; reset also forces req_ready low.
  assign w_accept  = rst_n && ena && w_any && (r_state == S_IDLE);
  assign w_ptr_nxt = (w_gnt == IDW'(NREQ-1)) ? '0 : w_gnt + IDW'(1);
  assign w_rsp_hs  = rsp_valid && rsp_ready;

  // One-hot ready for the winner and the winner's operand.
  always_comb begin
    req_ready = '0;
    w_gnt_x   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt == IDW'(i)) begin
        req_ready[i] = w_accept;
        w_gnt_x      = req_x[16*i +: 16];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state: accept -> wait out core latency -> hold response until taken.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)         w_state_nxt = S_WAIT;
      S_WAIT:  if (r_cnt == 4'd0)    w_state_nxt = S_RESP;
      S_RESP:  if (rsp_ready)        w_state_nxt = S_IDLE;
      default:                       w_state_nxt = S_IDLE;
    endcase
  end

  // Operand/result/id capture, latency countdown, pointer and completion count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr   <= '0;
      r_id       <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_cnt      <= '0;
      r_done_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_x      <= w_gnt_x;
        r_id     <= w_gnt;
        r_cnt    <= 4'(CORE_LAT);
        r_rr_ptr <= w_ptr_nxt;
      end
      if (r_state == S_WAIT) begin
        if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
        else               r_y   <= core_y;
      end
      if (w_rsp_hs) r_done_cnt <= r_done_cnt + 16'd1;
    end
  end

  assign rsp_valid = (r_state == S_RESP);
  assign busy      = (r_state != S_IDLE);
  assign rsp_id    = r_id;
  assign rsp_y     = r_y;
  assign core_x    = r_x;
  assign done_cnt  = r_done_cnt;

endmodule

// File: tb/tb_sigmoid_req_scheduler.sv
// Bench: two schedulers (core latency 0 and 3) on shared request stimulus, each with
// its own hard-sigmoid core stub (y = clamp(0.5 + x/4, 0, 1) in Q8.8).
module tb_sigmoid_req_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [63:0] req_x = '0;
  logic        rsp_ready = 1'b0;

  logic [3:0]  a_req_ready, b_req_ready;
  logic        a_rsp_valid, b_rsp_valid, a_busy, b_busy;
  logic [1:0]  a_rsp_id, b_rsp_id;
  logic [15:0] a_rsp_y, b_rsp_y, a_core_x, b_core_x, a_core_y, b_core_y, a_done, b_done;
  logic [15:0] b_pipe0, b_pipe1, b_pipe2;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] sig(input logic [15:0] x);
    int s;
    s = int'($signed(x));
    s = 128 + (s >>> 2);
    if (s < 0)   s = 0;
    if (s > 256) s = 256;
    return 16'(s);
  endfunction

  // latency-0 core: combinational; latency-3 core: valid only after 3 stable cycles
  assign a_core_y = sig(a_core_x);
  always @(posedge clk) begin
    b_pipe0 <= b_core_x;
    b_pipe1 <= b_pipe0;
    b_pipe2 <= b_pipe1;
  end
  assign b_core_y = sig(b_pipe2);

  sigmoid_req_scheduler #(.NREQ(4), .IDW(2), .CORE_LAT(0)) u_a (
    .clk(clk), .rst_n(rst_n), .ena(ena), .req_valid(req_valid), .req_x(req_x),
    .req_ready(a_req_ready), .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(a_rsp_id), .rsp_y(a_rsp_y), .core_x(a_core_x), .core_y(a_core_y),
    .busy(a_busy), .done_cnt(a_done));

  sigmoid_req_scheduler #(.NREQ(4), .IDW(2), .CORE_LAT(3)) u_b (
    .clk(clk), .rst_n(rst_n), .ena(ena), .req_valid(req_valid), .req_x(req_x),
    .req_ready(b_req_ready), .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(b_rsp_id), .rsp_y(b_rsp_y), .core_x(b_core_x), .core_y(b_core_y),
    .busy(b_busy), .done_cnt(b_done));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // One isolated operation on instance A (sel_b=0) or B (sel_b=1), consumer always ready.
  task automatic do_op(input bit sel_b, input logic [3:0] mask, input logic [63:0] xs,
                       output logic [3:0] gnt, output logic [1:0] id,
                       output logic [15:0] y, output int lat);
    int t;
    @(negedge clk);
    ena = 1'b1; rsp_ready = 1'b1; req_valid = mask; req_x = xs;
    #1;
    t = 0;
    gnt = sel_b ? b_req_ready : a_req_ready;
    while (gnt == 4'd0 && t < 100) begin
      @(negedge clk); #1; t++;
      gnt = sel_b ? b_req_ready : a_req_ready;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    lat = 0;
    while (!(sel_b ? b_rsp_valid : a_rsp_valid) && lat < 100) begin
      @(negedge clk); lat++;
    end
    id = sel_b ? b_rsp_id : a_rsp_id;
    y  = sel_b ? b_rsp_y  : a_rsp_y;
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = '0; ena = 1'b1; rsp_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_b_idle();
    int t;
    t = 0;
    @(negedge clk);
    req_valid = '0; rsp_ready = 1'b1;
    while (b_busy && t < 100) begin @(negedge clk); t++; end
  endtask

  typedef struct {
    logic [3:0]  mask;
    logic [63:0] xs;
    logic [1:0]  id;
    logic [15:0] y;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        tbl [9];
    logic [3:0]  g, expv, drop, s_v;
    logic [1:0]  id, m_id;
    logic [15:0] y, m_y, m_done;
    logic [15:0] s_x [4];
    int          lat, t, grants, order_err, multi, m_ptr, m_age, gi;
    bit          m_inf, exp_rv, hs;

    // mask, {x3,x2,x1,x0}, expected id, expected y (round-robin pointer from reset = 0)
    tbl[0] = '{4'b0001, 64'h0000_0000_0000_0000, 2'd0, 16'h0080};
    tbl[1] = '{4'b1010, 64'hFF00_0000_0100_0000, 2'd1, 16'h00C0};
    tbl[2] = '{4'b1000, 64'hFF00_0000_0000_0000, 2'd3, 16'h0040};
    tbl[3] = '{4'b1111, 64'h1111_2222_3333_0200, 2'd0, 16'h0100};
    tbl[4] = '{4'b0101, 64'h0000_8000_0000_7FFF, 2'd2, 16'h0000};
    tbl[5] = '{4'b0011, 64'h0000_0000_0500_0040, 2'd0, 16'h0090};
    tbl[6] = '{4'b0001, 64'h0000_0000_0000_FFC0, 2'd0, 16'h0070};
    tbl[7] = '{4'b1100, 64'h0300_0080_0000_0000, 2'd2, 16'h00A0};
    tbl[8] = '{4'b1100, 64'hFE80_0040_0000_0000, 2'd3, 16'h0020};

    // reset state
    #2;
    chk("rst req_ready", b_req_ready, 4'd0);
    chk("rst rsp_valid", b_rsp_valid, 1'b0);
    chk("rst rsp_id",    b_rsp_id, 2'd0);
    chk("rst rsp_y",     b_rsp_y, 16'd0);
    chk("rst core_x",    b_core_x, 16'd0);
    chk("rst busy",      b_busy, 1'b0);
    chk("rst done_cnt",  b_done, 16'd0);
    chk("rst a busy",    a_busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // vector table on the latency-0 instance
    for (int r = 0; r < 9; r++) begin
      do_op(1'b0, tbl[r].mask, tbl[r].xs, g, id, y, lat);
      expv = 4'(1 << tbl[r].id);
      chk($sformatf("vec%0d grant", r), g, expv);
      chk($sformatf("vec%0d id", r), id, tbl[r].id);
      chk($sformatf("vec%0d y", r), y, tbl[r].y);
      chk($sformatf("vec%0d latency", r), lat, 1);
    end
    chk("vec done_cnt", a_done, 16'd9);

    // all four requesters continuously valid for 12 ops
    pulse_reset();
    req_valid = 4'hF;
    req_x = 64'h0300_0200_0100_0000;
    grants = 0; order_err = 0; multi = 0; t = 0;
    while (grants < 12 && t < 300) begin
      #1;
      if (a_req_ready != 4'd0) begin
        if ($countones(a_req_ready) != 1) multi++;
        expv = 4'(1 << (grants % 4));
        if (a_req_ready != expv) order_err++;
        grants++;
      end
      if (grants < 12) begin @(negedge clk); t++; end
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    t = 0;
    while (a_busy && t < 50) begin @(negedge clk); t++; end
    chk("rr grants", grants, 12);
    chk("rr order errors", order_err, 0);
    chk("rr multi-hot", multi, 0);
    chk("rr done_cnt", a_done, 16'd12);

    // latency 3 with consumer back-pressure
    wait_b_idle();
    req_valid = 4'b0100; req_x = 64'h0000_0100_0000_0000; rsp_ready = 1'b0; ena = 1'b1;
    #1; t = 0;
    while (b_req_ready == 4'd0 && t < 50) begin @(negedge clk); #1; t++; end
    chk("bp grant", b_req_ready, 4'b0100);
    @(posedge clk);
    @(negedge clk);
    req_valid = 4'hF;
    lat = 0;
    while (!b_rsp_valid && lat < 50) begin @(negedge clk); lat++; end
    chk("bp latency", lat, 4);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp hold valid", b_rsp_valid, 1'b1);
      chk("bp hold y", b_rsp_y, 16'h00C0);
      chk("bp hold id", b_rsp_id, 2'd2);
      chk("bp no grant", b_req_ready, 4'd0);
      @(negedge clk);
    end
    req_valid = '0; rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp released", b_rsp_valid, 1'b0);

    // ena dropped while waiting on the core
    req_valid = 4'b0010; req_x = 64'h0000_0000_FF00_0000; ena = 1'b1; rsp_ready = 1'b0;
    #1; t = 0;
    while (b_req_ready == 4'd0 && t < 50) begin @(negedge clk); #1; t++; end
    chk("ena grant", b_req_ready, 4'b0010);
    @(posedge clk);
    @(negedge clk);
    ena = 1'b0; req_valid = 4'hF;
    t = 0;
    while (!b_rsp_valid && t < 50) begin @(negedge clk); t++; end
    chk("ena rsp delivered", b_rsp_valid, 1'b1);
    chk("ena rsp y", b_rsp_y, 16'h0040);
    chk("ena rsp id", b_rsp_id, 2'd1);
    rsp_ready = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("ena low no grant", b_req_ready, 4'd0);
      chk("ena low idle", b_busy, 1'b0);
      @(negedge clk);
    end
    req_valid = '0; ena = 1'b1;

    // reset during WAIT
    wait_b_idle();
    req_valid = 4'b0001; req_x = 64'h0000_0000_0000_0100;
    #1; t = 0;
    while (b_req_ready == 4'd0 && t < 50) begin @(negedge clk); #1; t++; end
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    chk("mid-op busy", b_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async rst busy", b_busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("post-rst rsp_valid", b_rsp_valid, 1'b0);
      chk("post-rst busy", b_busy, 1'b0);
      @(negedge clk);
    end
    chk("post-rst done_cnt", b_done, 16'd0);
    chk("post-rst core_x", b_core_x, 16'd0);

    // randomized traffic on the latency-3 instance against a transaction-timeline model
    m_ptr = 0; m_inf = 1'b0; m_age = 0; m_id = '0; m_y = '0; m_done = '0;
    s_v = '0; drop = '0;
    for (int i = 0; i < 4; i++) s_x[i] = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      exp_rv = m_inf && (m_age >= 4);
      chk("rnd rsp_valid", b_rsp_valid, exp_rv);
      chk("rnd busy", b_busy, m_inf);
      chk("rnd done_cnt", b_done, m_done);
      if (exp_rv) begin
        chk("rnd rsp_id", b_rsp_id, m_id);
        chk("rnd rsp_y", b_rsp_y, m_y);
      end
      for (int i = 0; i < 4; i++) begin
        if (drop[i]) s_v[i] = 1'b0;
        else if (s_v[i]) begin
          if ($urandom_range(9) == 0) s_v[i] = 1'b0;
        end else if ($urandom_range(9) < 4) begin
          s_v[i] = 1'b1;
          s_x[i] = 16'($urandom);
        end
      end
      drop = '0;
      ena = ($urandom_range(9) != 0);
      rsp_ready = ($urandom_range(9) < 6);
      req_valid = s_v;
      req_x = {s_x[3], s_x[2], s_x[1], s_x[0]};
      #1;
      gi = -1;
      if (!m_inf && ena)
        for (int k = 0; k < 4; k++)
          if (gi < 0 && s_v[(m_ptr + k) % 4]) gi = (m_ptr + k) % 4;
      expv = (gi < 0) ? 4'd0 : 4'(1 << gi);
      chk("rnd req_ready", b_req_ready, expv);
      hs = exp_rv && rsp_ready;
      if (m_inf) m_age++;
      if (hs) begin m_inf = 1'b0; m_done = m_done + 16'd1; end
      if (gi >= 0) begin
        m_inf = 1'b1; m_age = 0; m_id = 2'(gi); m_y = sig(s_x[gi]);
        m_ptr = (gi + 1) % 4;
        drop[gi] = 1'b1;
      end
    end

    // done_cnt wrap from 0xFFFF
    wait_b_idle();
    force u_b.r_done_cnt = 16'hFFFF;
    @(negedge clk);
    release u_b.r_done_cnt;
    #1;
    chk("preload done_cnt", b_done, 16'hFFFF);
    do_op(1'b1, 4'b0100, 64'h0000_0040_0000_0000, g, id, y, lat);
    chk("wrap grant", g, 4'b0100);
    chk("wrap latency", lat, 4);
    chk("wrap y", y, 16'h0090);
    chk("wrap id", id, 2'd2);
    chk("wrap done_cnt", b_done, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
